mmio_req_fifo: RTL

- Upstream stage of the MMIO RAM stress AFU: captures CCI-P c0 MMIO read/write requests (host cannot be back-pressured) into a FIFO.
- Presents them to the RAM/read-response backend over a valid/ready handshake.
- Tracks outstanding MMIO reads against the CCI-P limit of 64.
- Sticky overflow/limit flags and watermarks support stress-test diagnostics.

---
 rtl/mmio_req_fifo.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/mmio_req_fifo.sv
// MMIO request FIFO: captures CCI-P c0 MMIO reads/writes, presents them over valid/ready,
// and tracks outstanding reads. Optional length checking via MMIO_REQ_LEN_CHECK_EN.
module mmio_req_fifo #(
    parameter int DEPTH              = 64,
    parameter int MAX_OUTSTANDING_RD = 64
) (
    input  logic                     pClk,
    input  logic                     pck_cp2af_softReset_n,
    input  logic                     in_mmio_wr_valid,
    input  logic                     in_mmio_rd_valid,
    input  logic [15:0]              in_addr,
    input  logic [1:0]               in_length,
    input  logic [8:0]               in_tid,
    input  logic [63:0]              in_data,
    output logic                     req_valid,
    input  logic                     req_ready,
    output logic                     req_is_rd,
    output logic [15:0]              req_addr,
    output logic [1:0]               req_length,
    output logic [8:0]               req_tid,
    output logic [63:0]              req_data,
    input  logic                     rd_rsp_done,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [$clog2(DEPTH):0]   fifo_hwm,
    output logic [6:0]               outstanding_rd,
    output logic                     overflow_sticky,
    output logic                     rd_limit_sticky,
    output logic                     rsp_underflow_sticky
`ifdef MMIO_REQ_LEN_CHECK_EN
    ,
    output logic [15:0]              illegal_len_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 1 + 16 + 2 + 9 + 64;

    logic [EW-1:0]  mem [DEPTH];
    logic [AW-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]  count_reg, hwm_reg;
    logic [6:0]     out_rd_reg, out_rd_next;
    logic           overflow_reg, rd_limit_reg, underflow_reg;

    logic           any_req, both_req, push_is_rd, len_ok;
    logic           full, pop, push, rd_push;
    logic           overflow_evt, underflow_evt, limit_evt;
    logic [EW-1:0]  entry, head;

    assign any_req    = in_mmio_wr_valid | in_mmio_rd_valid;
    assign both_req   = in_mmio_wr_valid & in_mmio_rd_valid;
    // Write wins a same-cycle collision; the read is lost.
    assign push_is_rd = in_mmio_rd_valid & ~in_mmio_wr_valid;

`ifdef MMIO_REQ_LEN_CHECK_EN
    assign len_ok = ~in_length[1];
`else
    assign len_ok = 1'b1;
`endif

    assign full    = (count_reg == CW'(DEPTH));
    assign req_valid = (count_reg != '0);
    assign pop     = req_valid & req_ready;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign push    = any_req & len_ok & (~full | pop);
    assign rd_push = push & push_is_rd;

    assign overflow_evt = both_req | (any_req & len_ok & full & ~pop);

    assign entry = {push_is_rd, in_addr, in_length, in_tid, in_data};
    assign head  = mem[rd_ptr_reg];

    // Head fields read zero while empty so reset leaves every output at 0.
    assign req_is_rd  = req_valid & head[EW-1];
    assign req_addr   = req_valid ? head[90:75] : '0;
    assign req_length = req_valid ? head[74:73] : '0;
    assign req_tid    = req_valid ? head[72:64] : '0;
    assign req_data   = req_valid ? head[63:0]  : '0;

    always_ff @(posedge pClk) begin
        if (push) begin
            mem[wr_ptr_reg] <= entry;
        end
    end

    always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
        if (!pck_cp2af_softReset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            hwm_reg    <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
            if (count_reg > hwm_reg) hwm_reg <= count_reg;
        end
    end

    always_comb begin
        out_rd_next   = out_rd_reg;
        underflow_evt = 1'b0;
        if (rd_push && !rd_rsp_done) begin
            if (out_rd_reg != 7'd127) out_rd_next = out_rd_reg + 7'd1;
        end else if (!rd_push && rd_rsp_done) begin
            if (out_rd_reg == 7'd0) underflow_evt = 1'b1;
            else                    out_rd_next   = out_rd_reg - 7'd1;
        end
        limit_evt = int'(out_rd_next) > MAX_OUTSTANDING_RD;
    end

    always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
        if (!pck_cp2af_softReset_n) begin
            out_rd_reg    <= '0;
            overflow_reg  <= 1'b0;
            rd_limit_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            out_rd_reg <= out_rd_next;
            if (overflow_evt)  overflow_reg  <= 1'b1;
            if (limit_evt)     rd_limit_reg  <= 1'b1;
            if (underflow_evt) underflow_reg <= 1'b1;
        end
    end

`ifdef MMIO_REQ_LEN_CHECK_EN
    logic [15:0] illegal_cnt_reg;

    always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
        if (!pck_cp2af_softReset_n) begin
            illegal_cnt_reg <= '0;
        end else if (any_req && !len_ok && illegal_cnt_reg != 16'hFFFF) begin
            illegal_cnt_reg <= illegal_cnt_reg + 16'd1;
        end
    end

    assign illegal_len_cnt = illegal_cnt_reg;
`endif

    assign fifo_count           = count_reg;
    assign fifo_hwm             = hwm_reg;
    assign outstanding_rd       = out_rd_reg;
    assign overflow_sticky      = overflow_reg;
    assign rd_limit_sticky      = rd_limit_reg;
    assign rsp_underflow_sticky = underflow_reg;

endmodule
